mod_load_store_unit: RTL and testbench

//  Initiator side of the data-memory port: turns pipeline load/store requests into
//  mem_read/mem_write/data_address_1/write_data cycles; returns data on data_out_1.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_if.sv | 29 ++
 rtl/mod_lsu_lane_align.sv | 40 ++++
 rtl/mod_load_store_unit.sv | 120 ++++++++++++
 tb/tb_mod_load_store_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: op codes, FSM encoding, access size decode.
package lsu_pkg;

  localparam int MEM_WORDS_DEF = 64;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  function automatic logic is_store(lsu_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic lsu_size_e op_size(lsu_op_e op);
    lsu_size_e sz;
    case (op)
      OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
      OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
      default:              sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response handshake plus the data-memory port of the LSU.
// master = the LSU itself, slave = pipeline and memory side.
interface lsu_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       data_address_1;
  logic [31:0]       write_data;
  logic [31:0]       data_out_1;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, data_out_1,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, data_address_1, write_data
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, data_out_1,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, data_address_1, write_data
  );
endinterface

// File: rtl/mod_lsu_lane_align.sv
// Little-endian lane handling: load extract/extend and store merge into a word.
module mod_lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  byte_off,
  input  lsu_op_e     op,
  output logic [31:0] ld_result,
  output logic [31:0] st_merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Select the addressed lane and extend it per load flavour.
  always_comb begin
    ld_byte   = rd_word[{byte_off, 3'b000} +: 8];
    ld_half   = rd_word[{byte_off[1], 4'b0000} +: 16];
    ld_result = rd_word;
    case (op)
      OP_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_result = {24'h0, ld_byte};
      OP_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_result = {16'h0, ld_half};
      default: ld_result = rd_word;
    endcase
  end

  // Overlay the store lane onto the word just read; other lanes pass through.
  always_comb begin
    st_merged = rd_word;
    case (op)
      OP_SB:   st_merged[{byte_off, 3'b000} +: 8]     = wdata[7:0];
      OP_SH:   st_merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      default: st_merged = wdata;
    endcase
  end

endmodule

// File: rtl/mod_load_store_unit.sv
// Load/store unit: one request in flight, byte/half access via read-modify-write,
// misalignment and range errors answered without touching memory.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a request; latches op/addr/wdata on accept
//   RD      | mem_read cycle; load result or merged SB/SH word captured
//   WR      | mem_write cycle with merged word (SB/SH) or wdata (SW)
//   RESP    | one-cycle resp_valid pulse, then back to IDLE
module mod_load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int ADDR_W    = 32
) (
  input  logic  clk,
  input  logic  reset,
  lsu_if.master bus
);

  localparam logic [ADDR_W-1:0] MEM_WORDS_L = ADDR_W'(MEM_WORDS);

  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q;
  lsu_op_e           req_op;
  lsu_size_e         req_size;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       store_word_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              accept;
  logic              acc_err;
  logic [31:0]       ld_result;
  logic [31:0]       st_merged;

  assign req_op = lsu_op_e'(bus.req_op);
  assign accept = reset && (state_q == ST_IDLE) && bus.req_valid;

  // Classify the incoming request: misaligned for its size or beyond the memory.
  always_comb begin
    req_size = op_size(req_op);
    acc_err  = ((req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00)) ||
               ((req_size == SZ_HALF) && bus.req_addr[0]) ||
               ((bus.req_addr >> 2) >= MEM_WORDS_L);
  end

  mod_lsu_lane_align u_lane_align (
    .rd_word   (bus.data_out_1),
    .wdata     (store_word_q),
    .byte_off  (addr_q[1:0]),
    .op        (op_q),
    .ld_result (ld_result),
    .st_merged (st_merged)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (acc_err)              state_d = ST_RESP;
          else if (req_op == OP_SW) state_d = ST_WR;
          else                      state_d = ST_RD;
        end
      end
      ST_RD:   state_d = is_store(op_q) ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches and result capture; store_word_q doubles as the RMW buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q         <= OP_LW;
      addr_q       <= '0;
      store_word_q <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q         <= req_op;
            addr_q       <= bus.req_addr;
            store_word_q <= bus.req_wdata;
            rdata_q      <= '0;
            err_q        <= acc_err;
          end
        end
        ST_RD: begin
          if (is_store(op_q)) store_word_q <= st_merged;
          else                rdata_q      <= ld_result;
        end
        default: ;
      endcase
    end
  end

  // Output drive; strobes are gated by reset so nothing fires in a reset cycle.
  always_comb begin
    bus.req_ready      = reset && (state_q == ST_IDLE);
    bus.mem_read       = reset && (state_q == ST_RD);
    bus.mem_write      = reset && (state_q == ST_WR);
    bus.resp_valid     = reset && (state_q == ST_RESP);
    bus.resp_rdata     = rdata_q;
    bus.resp_err       = err_q;
    bus.data_address_1 = 32'(addr_q >> 2);
    bus.write_data     = bus.mem_write ? store_word_q : 32'h0;
  end

endmodule

// File: tb/tb_mod_load_store_unit.sv
module tb_mod_load_store_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  lsu_if #(.ADDR_W(32)) bus ();

  mod_load_store_unit #(.MEM_WORDS(64), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 | (32'(i) << 8) | 32'(i);
  endfunction

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.lat   = lat;
    return e;
  endfunction

  // Memory model and cycle bookkeeping.
  logic [31:0] mem [64];
  logic        mem_ready = 1'b0;
  int          cyc = 0, acc_cyc = 0, rd_cyc = 0, wr_cyc = 0;
  int          rd_count = 0, wr_count = 0;
  logic [31:0] wr_addr = 32'h0;

  assign bus.data_out_1 = mem[bus.data_address_1[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.data_address_1[5:0]] <= bus.write_data;
    end
    if (bus.req_valid && bus.req_ready) acc_cyc <= cyc + 1;
    if (bus.mem_read) begin
      rd_count <= rd_count + 1;
      rd_cyc   <= cyc + 1;
    end
    if (bus.mem_write) begin
      wr_count <= wr_count + 1;
      wr_cyc   <= cyc + 1;
      wr_addr  <= bus.data_address_1;
    end
  end

  // Scoreboard: pop and compare on every response pulse.
  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_lat;

  always @(negedge clk) begin
    n_checks++;
    if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) begin
      n_fail++;
      $display("FAIL rd_wr_overlap: mem_read and mem_write both 1 at cycle %0d", cyc);
    end
    if (bus.resp_valid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding, cycle %0d", cyc);
      end else begin
        mon_e   = sb_q.pop_front();
        mon_lat = cyc - acc_cyc + 1;
        if (bus.resp_rdata !== mon_e.rdata) begin
          n_fail++;
          $display("FAIL resp_rdata: got %h expected %h", bus.resp_rdata, mon_e.rdata);
        end
        n_checks++;
        if (bus.resp_err !== mon_e.err) begin
          n_fail++;
          $display("FAIL resp_err: got %b expected %b", bus.resp_err, mon_e.err);
        end
        n_checks++;
        if (mon_lat != mon_e.lat) begin
          n_fail++;
          $display("FAIL resp_latency: got %0d expected %0d", mon_lat, mon_e.lat);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input exp_t e);
    int k = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    sb_q.push_back(e);
    while (bus.req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (k >= 50) begin
      n_fail++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL resp_timeout: %0d responses outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    int wr0 = wr_count;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.mem_write, bus.mem_read, bus.req_ready, bus.resp_valid, bus.resp_err} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_strobes: wr/rd/ready/valid/err=%b required 00000",
                 {bus.mem_write, bus.mem_read, bus.req_ready, bus.resp_valid, bus.resp_err});
      end
      n_checks++;
      if (bus.write_data !== 32'h0 || bus.data_address_1 !== 32'h0 || bus.resp_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_data: wdata=%h addr=%h rdata=%h required all 0",
                 bus.write_data, bus.data_address_1, bus.resp_rdata);
      end
    end
    reset = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b required 1", bus.req_ready);
    end
    n_checks++;
    if (wr_count != wr0) begin
      n_fail++;
      $display("FAIL reset_no_write: %0d writes required 0", wr_count - wr0);
    end
  endtask

  task automatic test_store_load();
    send(SW, 32'h10, 32'hDEADBEEF, mk(32'h0, 1'b0, 2));
    wait_done();
    n_checks++;
    if (wr_addr !== 32'd4 || wr_cyc - acc_cyc != 1) begin
      n_fail++;
      $display("FAIL sw_write_cycle: word %0d at +%0d required word 4 at +1", wr_addr, wr_cyc - acc_cyc);
    end
    n_checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_mem: got %h required deadbeef", mem[4]);
    end
    send(LW, 32'h10, 32'h0, mk(32'hDEADBEEF, 1'b0, 2));
    wait_done();
  endtask

  task automatic test_sub_word_loads();
    logic [2:0]  t_op   [7] = '{LB, LBU, LH, LHU, LB, LBU, LH};
    logic [31:0] t_addr [7] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11, 32'h10};
    logic [31:0] t_exp  [7] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF,
                                32'hFFFFFFEF, 32'h000000BE, 32'hFFFFBEEF};
    for (int i = 0; i < 7; i++) begin
      send(t_op[i], t_addr[i], 32'h0, mk(t_exp[i], 1'b0, 2));
      wait_done();
    end
  endtask

  task automatic test_sub_word_stores();
    int rd0 = rd_count;
    int wr0 = wr_count;
    send(SB, 32'h11, 32'hAABBCC55, mk(32'h0, 1'b0, 3));
    wait_done();
    n_checks++;
    if (rd_count - rd0 != 1 || wr_count - wr0 != 1) begin
      n_fail++;
      $display("FAIL sb_mem_cycles: rd=%0d wr=%0d required 1 and 1", rd_count - rd0, wr_count - wr0);
    end
    n_checks++;
    if (rd_cyc - acc_cyc != 1 || wr_cyc - acc_cyc != 2) begin
      n_fail++;
      $display("FAIL sb_cycle_order: rd +%0d wr +%0d required +1 and +2", rd_cyc - acc_cyc, wr_cyc - acc_cyc);
    end
    send(LW, 32'h10, 32'h0, mk(32'hDEAD55EF, 1'b0, 2));
    wait_done();
    send(SH, 32'h12, 32'hFFFF1234, mk(32'h0, 1'b0, 3));
    wait_done();
    n_checks++;
    if (mem[4] !== 32'h123455EF) begin
      n_fail++;
      $display("FAIL sh_mem: got %h required 123455ef", mem[4]);
    end
    send(LB, 32'h11, 32'h0, mk(32'h00000055, 1'b0, 2));
    wait_done();
  endtask

  task automatic test_errors();
    logic [2:0]  t_op   [6] = '{LW, SH, LW, SB, SW, LHU};
    logic [31:0] t_addr [6] = '{32'h12, 32'h13, 32'h100, 32'h100, 32'hFE, 32'h11};
    logic [31:0] w63 = init_word(63);
    int rd0 = rd_count;
    int wr0 = wr_count;
    for (int i = 0; i < 6; i++) begin
      send(t_op[i], t_addr[i], 32'h11112222, mk(32'h0, 1'b1, 1));
      wait_done();
    end
    n_checks++;
    if (rd_count != rd0 || wr_count != wr0) begin
      n_fail++;
      $display("FAIL err_no_mem: rd=%0d wr=%0d required 0 and 0", rd_count - rd0, wr_count - wr0);
    end
    send(LW, 32'hFC, 32'h0, mk(w63, 1'b0, 2));
    wait_done();
    send(LB, 32'hFF, 32'h0, mk(32'hFFFFFFA5, 1'b0, 2));
    wait_done();
  endtask

  task automatic test_back_to_back();
    int a [5];
    send(LW, 32'h10, 32'h0, mk(32'h123455EF, 1'b0, 2));
    a[0] = acc_cyc;
    send(LH, 32'h12, 32'h0, mk(32'h00001234, 1'b0, 2));
    a[1] = acc_cyc;
    send(LBU, 32'h13, 32'h0, mk(32'h00000012, 1'b0, 2));
    a[2] = acc_cyc;
    send(LW, 32'h01, 32'h0, mk(32'h0, 1'b1, 1));
    a[3] = acc_cyc;
    send(LHU, 32'h12, 32'h0, mk(32'h00001234, 1'b0, 2));
    a[4] = acc_cyc;
    wait_done();
    n_checks++;
    if (a[1] - a[0] != 3 || a[2] - a[1] != 3 || a[3] - a[2] != 3 || a[4] - a[3] != 2) begin
      n_fail++;
      $display("FAIL b2b_spacing: gaps %0d %0d %0d %0d required 3 3 3 2",
               a[1] - a[0], a[2] - a[1], a[3] - a[2], a[4] - a[3]);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] w8 = init_word(8);
    int rd0 = rd_count;
    int wr0 = wr_count;
    int k = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = SH;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h0000BEEF;
    while (bus.req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (k >= 50) begin
      n_fail++;
      $display("FAIL abort_accept_timeout: req_ready stayed %b, required 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_read_gated: mem_read=%b required 0", bus.mem_read);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: req_ready=%b required 1", bus.req_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_count != wr0 || rd_count != rd0 || mem[8] !== w8) begin
      n_fail++;
      $display("FAIL abort_mem: wr=%0d rd=%0d word8=%h required 0 0 %h",
               wr_count - wr0, rd_count - rd0, mem[8], w8);
    end
    send(LW, 32'h20, 32'h0, mk(w8, 1'b0, 2));
    wait_done();
    send(SH, 32'h22, 32'h00007777, mk(32'h0, 1'b0, 3));
    wait_done();
    send(LW, 32'h20, 32'h0, mk({16'h7777, w8[15:0]}, 1'b0, 2));
    wait_done();
  endtask

  initial begin
    reset         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = SW;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h12345678;
    test_reset();
    test_store_load();
    test_sub_word_loads();
    test_sub_word_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
